// File: rtl/branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// branch_resolve_unit
//
// Resolves conditional branches in decode and keeps a table of 2-bit
// saturating counters (the BHT) that predicts branch direction for fetch.
//
// Parameters
//   WIDTH      operand width of DataA/DataB
//   BHT_DEPTH  number of 2-bit counters (power of two, >= 2)
//   PC_WIDTH   program-counter width
//
// Ports
//   Clock, Reset_n        rising-edge clock, asynchronous active-low reset
//   LookupPC, PredTaken   fetch-side lookup; PredTaken is the counter MSB
//   Valid, Stall          decode qualifiers; a stalled/invalid slot is ignored
//   Opcode, Rt            decode fields selecting the branch kind
//   BranchPC              PC of the decoding instruction (selects the counter)
//   DataA, DataB          forwarded rs/rt operands
//   IsBranch              combinational: Opcode/Rt is a supported branch
//   Taken, Mispredict     registered resolution result and flush pulse
//
// Optional feature (macro BRANCH_STATS_EN)
//   Adds BranchCount / MispredCount, 32-bit wrapping event counters.
// ----------------------------------------------------------------------------
module branch_resolve_unit #(
    parameter int WIDTH     = 32,
    parameter int BHT_DEPTH = 16,
    parameter int PC_WIDTH  = 32
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic [PC_WIDTH-1:0] LookupPC,
    output logic                PredTaken,
    input  logic                Valid,
    input  logic                Stall,
    input  logic [5:0]          Opcode,
    input  logic [4:0]          Rt,
    input  logic [PC_WIDTH-1:0] BranchPC,
    input  logic [WIDTH-1:0]    DataA,
    input  logic [WIDTH-1:0]    DataB,
    output logic                IsBranch,
    output logic                Taken,
    output logic                Mispredict
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]         BranchCount,
    output logic [31:0]         MispredCount
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    // Saturating 2-bit counter step: up on taken, down on not-taken.
    function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
        logic [1:0] res;
        case ({up, cnt})
            3'b1_11: res = 2'b11;
            3'b0_00: res = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: res = cnt + 2'd1;
            3'b0_01, 3'b0_10, 3'b0_11: res = cnt - 2'd1;
            default: res = cnt;
        endcase
        return res;
    endfunction

    logic [BHT_DEPTH-1:0][1:0] bht_q, bht_d;
    logic                      taken_q, taken_d;
    logic                      mispredict_q, mispredict_d;
    logic [IDX_W-1:0]          lookup_idx_s, branch_idx_s;
    logic                      is_branch_s, cond_s, resolve_s;
    logic                      a_neg_s, a_zero_s;
    logic                      unused_pc_bits_s;

    assign lookup_idx_s = LookupPC[IDX_W+1:2];
    assign branch_idx_s = BranchPC[IDX_W+1:2];

    // PC bits outside the index field do not participate in prediction.
    assign unused_pc_bits_s = ^{LookupPC[PC_WIDTH-1:IDX_W+2], LookupPC[1:0],
                                BranchPC[PC_WIDTH-1:IDX_W+2], BranchPC[1:0]};

    assign a_neg_s  = DataA[WIDTH-1];
    assign a_zero_s = (DataA == {WIDTH{1'b0}});

    // Branch decode and condition evaluation.
    always_comb begin
        is_branch_s = 1'b0;
        cond_s      = 1'b0;
        case (Opcode)
            6'b000100: begin is_branch_s = 1'b1; cond_s = (DataA == DataB);      end
            6'b000101: begin is_branch_s = 1'b1; cond_s = (DataA != DataB);      end
            6'b000110: begin is_branch_s = 1'b1; cond_s = a_neg_s | a_zero_s;    end
            6'b000111: begin is_branch_s = 1'b1; cond_s = ~a_neg_s & ~a_zero_s;  end
            6'b000001: begin
                case (Rt)
                    5'b00000: begin is_branch_s = 1'b1; cond_s = a_neg_s;  end
                    5'b00001: begin is_branch_s = 1'b1; cond_s = ~a_neg_s; end
                    default:  begin is_branch_s = 1'b0; cond_s = 1'b0;     end
                endcase
            end
            default: begin
                is_branch_s = 1'b0;
                cond_s      = 1'b0;
            end
        endcase
    end

    assign resolve_s = Valid & ~Stall & is_branch_s;

    // Next-state: counter update, resolved direction and flush pulse.
    always_comb begin
        bht_d        = bht_q;
        taken_d      = taken_q;
        mispredict_d = 1'b0;
        if (resolve_s) begin
            taken_d              = cond_s;
            mispredict_d         = cond_s ^ bht_q[branch_idx_s][1];
            bht_d[branch_idx_s]  = sat_step(bht_q[branch_idx_s], cond_s);
        end else begin
            taken_d      = taken_q;
            mispredict_d = 1'b0;
        end
    end

    // State registers; reset leaves every counter weakly not-taken.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            bht_q        <= {BHT_DEPTH{2'b01}};
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            bht_q        <= bht_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    // Prediction reads the current state; an update in flight is not bypassed.
    assign PredTaken  = bht_q[lookup_idx_s][1];
    assign IsBranch   = is_branch_s;
    assign Taken      = taken_q;
    assign Mispredict = mispredict_q;

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_count_q, branch_count_d;
    logic [31:0] mispred_count_q, mispred_count_d;

    // Event counters, wrapping naturally at 2^32.
    always_comb begin
        branch_count_d  = branch_count_q;
        mispred_count_d = mispred_count_q;
        if (resolve_s) begin
            branch_count_d = branch_count_q + 32'd1;
            if (cond_s ^ bht_q[branch_idx_s][1]) begin
                mispred_count_d = mispred_count_q + 32'd1;
            end else begin
                mispred_count_d = mispred_count_q;
            end
        end else begin
            branch_count_d  = branch_count_q;
            mispred_count_d = mispred_count_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            branch_count_q  <= 32'd0;
            mispred_count_q <= 32'd0;
        end else begin
            branch_count_q  <= branch_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign BranchCount  = branch_count_q;
    assign MispredCount = mispred_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// ----------------------------------------------------------------------------
// tb_branch_resolve_unit
//
// Directed self-checking bench for branch_resolve_unit with default
// parameters (16-entry BHT, index = PC[5:2]). Counter state is observed
// through PredTaken via LookupPC. Statistics checks are compiled in when
// BRANCH_STATS_EN is defined.
// ----------------------------------------------------------------------------
module tb_branch_resolve_unit;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    logic        Clock;
    logic        Reset_n;
    logic [31:0] LookupPC;
    logic        PredTaken;
    logic        Valid;
    logic        Stall;
    logic [5:0]  Opcode;
    logic [4:0]  Rt;
    logic [31:0] BranchPC;
    logic [31:0] DataA;
    logic [31:0] DataB;
    logic        IsBranch;
    logic        Taken;
    logic        Mispredict;
`ifdef BRANCH_STATS_EN
    logic [31:0] BranchCount;
    logic [31:0] MispredCount;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    branch_resolve_unit dut (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .LookupPC   (LookupPC),
        .PredTaken  (PredTaken),
        .Valid      (Valid),
        .Stall      (Stall),
        .Opcode     (Opcode),
        .Rt         (Rt),
        .BranchPC   (BranchPC),
        .DataA      (DataA),
        .DataB      (DataB),
        .IsBranch   (IsBranch),
        .Taken      (Taken),
        .Mispredict (Mispredict)
`ifdef BRANCH_STATS_EN
        ,
        .BranchCount  (BranchCount),
        .MispredCount (MispredCount)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic drive(input logic [5:0] op, input logic [4:0] rt, input logic [31:0] pc,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic v, input logic st);
        Opcode = op; Rt = rt; BranchPC = pc; DataA = a; DataB = b; Valid = v; Stall = st;
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle();
        Valid = 1'b0; Stall = 1'b0;
    endtask

    task automatic test_reset();
        Reset_n = 1'b0;
        idle();
        drive(6'b000000, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
        LookupPC = 32'h0;
        repeat (2) @(posedge Clock);
        #1;
        total_cnt++; if (Taken !== 1'b0) $display("FAIL reset_taken: got %b want 0", Taken); else pass_cnt++;
        total_cnt++; if (Mispredict !== 1'b0) $display("FAIL reset_mispredict: got %b want 0", Mispredict); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            LookupPC = 32'(i) << 2;
            #1;
            total_cnt++; if (PredTaken !== 1'b0) $display("FAIL reset_pred[%0d]: got %b want 0", i, PredTaken); else pass_cnt++;
        end
`ifdef BRANCH_STATS_EN
        total_cnt++; if (BranchCount !== 32'd0) $display("FAIL reset_bcount: got %0d want 0", BranchCount); else pass_cnt++;
        total_cnt++; if (MispredCount !== 32'd0) $display("FAIL reset_mcount: got %0d want 0", MispredCount); else pass_cnt++;
`endif
        @(negedge Clock);
        Reset_n = 1'b1;
        step();
    endtask

    // BEQ taken on a weakly-not-taken entry: mispredict, counter 01 -> 10.
    task automatic test_beq();
        drive(OP_BEQ, 5'd0, 32'h40, 32'h1234, 32'h1234, 1'b1, 1'b0);
        #1;
        total_cnt++; if (IsBranch !== 1'b1) $display("FAIL beq_isbranch: got %b want 1", IsBranch); else pass_cnt++;
        step();
        idle();
        total_cnt++; if (Taken !== 1'b1) $display("FAIL beq_taken: got %b want 1", Taken); else pass_cnt++;
        total_cnt++; if (Mispredict !== 1'b1) $display("FAIL beq_mispredict: got %b want 1", Mispredict); else pass_cnt++;
        LookupPC = 32'h40; #1;
        total_cnt++; if (PredTaken !== 1'b1) $display("FAIL beq_pred: got %b want 1", PredTaken); else pass_cnt++;
        step();
        total_cnt++; if (Mispredict !== 1'b0) $display("FAIL beq_pulse_end: got %b want 0", Mispredict); else pass_cnt++;
        total_cnt++; if (Taken !== 1'b1) $display("FAIL beq_taken_hold: got %b want 1", Taken); else pass_cnt++;
    endtask

    // Four taken BNEs at idx0 (10 -> 11 saturating), then two not-taken.
    task automatic test_bne_saturate();
        drive(OP_BNE, 5'd0, 32'h40, 32'h1, 32'h2, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++; if (Mispredict !== 1'b0) $display("FAIL bne_mis[%0d]: got %b want 0", i, Mispredict); else pass_cnt++;
            total_cnt++; if (Taken !== 1'b1) $display("FAIL bne_taken[%0d]: got %b want 1", i, Taken); else pass_cnt++;
        end
        idle();
        LookupPC = 32'h40; #1;
        total_cnt++; if (PredTaken !== 1'b1) $display("FAIL bne_pred_sat: got %b want 1", PredTaken); else pass_cnt++;
        // Not-taken: 11 -> 10, prediction still taken if it really saturated.
        drive(OP_BNE, 5'd0, 32'h40, 32'h7, 32'h7, 1'b1, 1'b0);
        step();
        idle();
        total_cnt++; if (Mispredict !== 1'b1) $display("FAIL bne_nt1_mis: got %b want 1", Mispredict); else pass_cnt++;
        total_cnt++; if (Taken !== 1'b0) $display("FAIL bne_nt1_taken: got %b want 0", Taken); else pass_cnt++;
        total_cnt++; if (PredTaken !== 1'b1) $display("FAIL bne_nt1_pred: got %b want 1", PredTaken); else pass_cnt++;
        drive(OP_BNE, 5'd0, 32'h40, 32'h7, 32'h7, 1'b1, 1'b0);
        step();
        idle();
        total_cnt++; if (PredTaken !== 1'b0) $display("FAIL bne_nt2_pred: got %b want 0", PredTaken); else pass_cnt++;
    endtask

    // Two consecutive mispredicting events at idx1 give two adjacent pulses.
    task automatic test_back_to_back();
        drive(OP_BEQ, 5'd0, 32'h44, 32'h5, 32'h5, 1'b1, 1'b0);
        step();
        total_cnt++; if (Mispredict !== 1'b1) $display("FAIL b2b_first: got %b want 1", Mispredict); else pass_cnt++;
        drive(OP_BEQ, 5'd0, 32'h44, 32'h5, 32'h6, 1'b1, 1'b0);
        step();
        idle();
        total_cnt++; if (Mispredict !== 1'b1) $display("FAIL b2b_second: got %b want 1", Mispredict); else pass_cnt++;
        total_cnt++; if (Taken !== 1'b0) $display("FAIL b2b_taken: got %b want 0", Taken); else pass_cnt++;
        step();
        total_cnt++; if (Mispredict !== 1'b0) $display("FAIL b2b_idle: got %b want 0", Mispredict); else pass_cnt++;
    endtask

    task automatic test_signed_branches();
        // BLTZ negative -> taken (idx2, mispredict)
        drive(OP_REGIMM, 5'b00000, 32'h48, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b1) $display("FAIL bltz_taken: got %b want 1", Taken); else pass_cnt++;
        total_cnt++; if (Mispredict !== 1'b1) $display("FAIL bltz_mis: got %b want 1", Mispredict); else pass_cnt++;
        // BGTZ zero -> not taken (idx4, counter 01 -> 00)
        drive(OP_BGTZ, 5'd0, 32'h50, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b0) $display("FAIL bgtz_zero: got %b want 0", Taken); else pass_cnt++;
        total_cnt++; if (Mispredict !== 1'b0) $display("FAIL bgtz_zero_mis: got %b want 0", Mispredict); else pass_cnt++;
        // BGEZ zero -> taken (idx3)
        drive(OP_REGIMM, 5'b00001, 32'h4C, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b1) $display("FAIL bgez_zero: got %b want 1", Taken); else pass_cnt++;
        // BGTZ negative -> not taken
        drive(OP_BGTZ, 5'd0, 32'h50, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b0) $display("FAIL bgtz_neg: got %b want 0", Taken); else pass_cnt++;
        // BLEZ zero -> taken
        drive(OP_BLEZ, 5'd0, 32'h50, 32'h0, 32'h0, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b1) $display("FAIL blez_zero: got %b want 1", Taken); else pass_cnt++;
        // BLEZ positive -> not taken
        drive(OP_BLEZ, 5'd0, 32'h50, 32'h1, 32'h0, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b0) $display("FAIL blez_pos: got %b want 0", Taken); else pass_cnt++;
        // BGTZ positive -> taken
        drive(OP_BGTZ, 5'd0, 32'h50, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b1) $display("FAIL bgtz_pos: got %b want 1", Taken); else pass_cnt++;
        // Unsupported REGIMM Rt=00010: no branch, no state change (Taken holds 1)
        drive(OP_REGIMM, 5'b00010, 32'h54, 32'h8000_0000, 32'h0, 1'b1, 1'b0);
        #1;
        total_cnt++; if (IsBranch !== 1'b0) $display("FAIL regimm_bad_isbranch: got %b want 0", IsBranch); else pass_cnt++;
        step();
        idle();
        total_cnt++; if (Mispredict !== 1'b0) $display("FAIL regimm_bad_mis: got %b want 0", Mispredict); else pass_cnt++;
        total_cnt++; if (Taken !== 1'b1) $display("FAIL regimm_bad_taken: got %b want 1", Taken); else pass_cnt++;
        LookupPC = 32'h54; #1;
        total_cnt++; if (PredTaken !== 1'b0) $display("FAIL regimm_bad_bht: got %b want 0", PredTaken); else pass_cnt++;
        Opcode = 6'b100011; #1;
        total_cnt++; if (IsBranch !== 1'b0) $display("FAIL lw_isbranch: got %b want 0", IsBranch); else pass_cnt++;
    endtask

    task automatic test_stall();
        // Known not-taken event at idx7 so Taken = 0 beforehand
        drive(OP_BNE, 5'd0, 32'h5C, 32'h3, 32'h3, 1'b1, 1'b0);
        step();
        total_cnt++; if (Taken !== 1'b0) $display("FAIL stall_pre_taken: got %b want 0", Taken); else pass_cnt++;
        // Stalled BEQ taken at idx6
        drive(OP_BEQ, 5'd0, 32'h58, 32'h9, 32'h9, 1'b1, 1'b1);
        step();
        total_cnt++; if (Mispredict !== 1'b0) $display("FAIL stall_mis: got %b want 0", Mispredict); else pass_cnt++;
        total_cnt++; if (Taken !== 1'b0) $display("FAIL stall_taken: got %b want 0", Taken); else pass_cnt++;
        // Invalid BEQ taken at idx6
        drive(OP_BEQ, 5'd0, 32'h58, 32'h9, 32'h9, 1'b0, 1'b0);
        step();
        idle();
        total_cnt++; if (Taken !== 1'b0) $display("FAIL invalid_taken: got %b want 0", Taken); else pass_cnt++;
        LookupPC = 32'h58; #1;
        total_cnt++; if (PredTaken !== 1'b0) $display("FAIL stall_bht: got %b want 0", PredTaken); else pass_cnt++;
    endtask

    // Same-index lookup during a resolve sees the pre-update counter.
    task automatic test_no_bypass();
        LookupPC = 32'h60;
        drive(OP_BEQ, 5'd0, 32'h60, 32'h1, 32'h1, 1'b1, 1'b0);
        #1;
        total_cnt++; if (PredTaken !== 1'b0) $display("FAIL nobypass_pre: got %b want 0", PredTaken); else pass_cnt++;
        step();
        idle();
        total_cnt++; if (PredTaken !== 1'b1) $display("FAIL nobypass_post: got %b want 1", PredTaken); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        drive(OP_BEQ, 5'd0, 32'h70, 32'h2, 32'h2, 1'b1, 1'b0);
        repeat (3) step();
        LookupPC = 32'h70; #1;
        total_cnt++; if (PredTaken !== 1'b1) $display("FAIL midrst_pre_pred: got %b want 1", PredTaken); else pass_cnt++;
        // Event still pending when reset hits between edges
        #1 Reset_n = 1'b0;
        #1;
        total_cnt++; if (Taken !== 1'b0) $display("FAIL midrst_taken: got %b want 0", Taken); else pass_cnt++;
        total_cnt++; if (Mispredict !== 1'b0) $display("FAIL midrst_mis: got %b want 0", Mispredict); else pass_cnt++;
        total_cnt++; if (PredTaken !== 1'b0) $display("FAIL midrst_pred: got %b want 0", PredTaken); else pass_cnt++;
`ifdef BRANCH_STATS_EN
        total_cnt++; if (BranchCount !== 32'd0) $display("FAIL midrst_bcount: got %0d want 0", BranchCount); else pass_cnt++;
        total_cnt++; if (MispredCount !== 32'd0) $display("FAIL midrst_mcount: got %0d want 0", MispredCount); else pass_cnt++;
`endif
        @(negedge Clock);
        Reset_n = 1'b1;
        // First edge after release resolves normally: 01 -> 10, mispredict.
        step();
        idle();
        total_cnt++; if (Mispredict !== 1'b1) $display("FAIL postrst_mis: got %b want 1", Mispredict); else pass_cnt++;
        total_cnt++; if (PredTaken !== 1'b1) $display("FAIL postrst_pred: got %b want 1", PredTaken); else pass_cnt++;
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        Reset_n = 1'b0;
        idle();
        #3;
        @(negedge Clock);
        Reset_n = 1'b1;
        drive(OP_BEQ, 5'd0, 32'h40, 32'h1, 32'h1, 1'b1, 1'b0);   // mis, 01->10
        step();
        step();                                                   // hit, 10->11
        drive(OP_BEQ, 5'd0, 32'h40, 32'h1, 32'h1, 1'b1, 1'b1);   // stalled: ignored
        step();
        drive(OP_BEQ, 5'd0, 32'h40, 32'h1, 32'h1, 1'b1, 1'b0);   // hit, 11
        step();
        drive(OP_BNE, 5'd0, 32'h40, 32'h4, 32'h4, 1'b1, 1'b0);   // mis, 11->10
        step();
        drive(OP_BGTZ, 5'd0, 32'h40, 32'h1, 32'h0, 1'b1, 1'b0);  // hit, 10->11
        step();
        idle();
        total_cnt++; if (BranchCount !== 32'd5) $display("FAIL stats_bcount: got %0d want 5", BranchCount); else pass_cnt++;
        total_cnt++; if (MispredCount !== 32'd2) $display("FAIL stats_mcount: got %0d want 2", MispredCount); else pass_cnt++;
    endtask
`endif

    initial begin
        test_reset();
        test_beq();
        test_bne_saturate();
        test_back_to_back();
        test_signed_branches();
        test_stall();
        test_no_bypass();
        test_reset_mid();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand width of DataA/DataB.
REQ-002 Parameter BHT_DEPTH, default 16: number of 2-bit predictor entries; power of two, minimum 2.
REQ-003 Parameter PC_WIDTH, default 32: program-counter width.
REQ-004 Clock  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 LookupPC  input  PC_WIDTH  fetch-stage PC for prediction lookup.
REQ-007 PredTaken  output  1  combinational: MSB of BHT entry indexed by LookupPC.
REQ-008 Valid  input  1  decode-stage instruction valid.
REQ-009 Stall  input  1  decode-stage hold; suppresses resolution.
REQ-010 Opcode  input  6  decode-stage opcode.
REQ-011 Rt  input  5  decode-stage rt field (REGIMM sub-op).
REQ-012 BranchPC  input  PC_WIDTH  PC of the decode-stage instruction.
REQ-013 DataA, DataB  input  WIDTH  forwarded rs/rt operands.
REQ-014 IsBranch  output  1  combinational: Opcode/Rt decode to a supported branch.
REQ-015 Taken  output  1  registered resolved direction.
REQ-016 Mispredict  output  1  registered one-cycle flush pulse.

Function
REQ-017 Index = PC[log2(BHT_DEPTH)+1:2], for both LookupPC and BranchPC.
REQ-018 Supported branches:
  - BEQ 000100: A==B
  - BNE 000101: A!=B
  - BLEZ 000110: signed A<=0
  - BGTZ 000111: signed A>0
  - REGIMM 000001 with Rt 00000 (BLTZ): signed A<0
  - REGIMM 000001 with Rt 00001 (BGEZ): signed A>=0
  All other encodings give IsBranch=0.
REQ-019 Equality compares all WIDTH bits. Signed tests use only DataA, with DataA[WIDTH-1] as the sign bit.
REQ-020 A resolve event occurs in cycle N when Valid=1, Stall=0 and IsBranch=1.
REQ-021 For a resolve event in cycle N:
  - Taken = condition result, registered at the end of cycle N.
  - Mispredict = (condition != MSB of BHT[index(BranchPC)] as read in cycle N).
  - Both are visible during cycle N+1.
REQ-022 In any cycle with no resolve event, Mispredict = 0 next cycle and Taken holds its previous value.
REQ-023 On a resolve event, the indexed 2-bit saturating counter updates at the same edge:
  - taken: increment, saturating at 11.
  - not-taken: decrement, saturating at 00.
REQ-024 If LookupPC and BranchPC share an index in the same cycle, PredTaken returns the pre-update value (no bypass).
REQ-025 Stall=1 or Valid=0 blocks all state changes, including BHT and statistics.
REQ-026 Mispredict is a single-cycle pulse per event. Back-to-back resolve events produce back-to-back pulses.

Reset
REQ-027 While Reset_n=0: all BHT entries = 01 (weakly not-taken), Taken=0, Mispredict=0, statistics counters = 0.
REQ-028 Reset asserted mid-operation discards any in-flight update. The first edge after release performs normal operation.

Configuration
REQ-029 With BRANCH_STATS_EN defined, the block adds two outputs:
  - BranchCount [31:0]: +1 per resolve event.
  - MispredCount [31:0]: +1 per mispredicting event.
  Both wrap modulo 2^32.
REQ-030 Without BRANCH_STATS_EN, these ports and their registers do not exist and all other behaviour is identical.

Verification
REQ-031 After reset, BEQ with DataA=DataB=0x1234, BranchPC=0x40 -> next cycle Taken=1, Mispredict=1; BHT[0] becomes 10.
REQ-032 BNE at the same PC four times with A!=B -> Mispredict pattern 0,0,0,0; BHT[0] saturates at 11; LookupPC=0x40 gives PredTaken=1.
REQ-033 BLTZ with DataA=0x80000000 -> Taken=1. BGEZ with DataA=0 -> Taken=1. BGTZ with DataA=0 -> Taken=0. Opcode 000001 with Rt=00010 -> IsBranch=0 and no update.
REQ-034 BEQ taken event with Stall=1 -> Mispredict stays 0, BHT unchanged, BranchCount unchanged.
REQ-035 Reset_n pulsed low mid-stream after three taken updates -> all entries read 01, Taken=0, counters 0.
REQ-036 With BRANCH_STATS_EN: 5 resolve events including 2 mispredicts -> BranchCount=5, MispredCount=2.
